// File: rtl/bp_pkg.sv
// bp_pkg: shared opcodes, counter type and pending-queue entry for branch_predictor (BP_GLOBAL_HISTORY_EN adds a history field).
package bp_pkg;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic OP_JUMP_MSB = 1'b1;
  localparam int AW_DEF = 11;
  localparam int IDX_DEF = 4;
  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_RESET = 2'b01;
  typedef struct packed {
`ifdef BP_GLOBAL_HISTORY_EN
    logic [IDX_DEF-1:0] hist;
`endif
    logic [IDX_DEF-1:0] idx;
    logic               pred;
    logic [AW_DEF-1:0]  target;
    logic [AW_DEF-1:0]  fall;
  } pend_t;
endpackage

// File: rtl/bp_pending_fifo.sv
// bp_pending_fifo: in-order queue of predicted branches; flush beats push and pop.
module bp_pending_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = pend_t,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  T              data_i,
  output T              head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  T mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign head_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  always_ff @(posedge clk) if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit counter predictor with in-order pending queue; BP_GLOBAL_HISTORY_EN XORs a global history into the index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IW = 22,
  parameter int AW = AW_DEF,
  parameter int IDX_BITS = IDX_DEF,
  parameter int PEND_DEPTH = 4,
  localparam int CW = $clog2(PEND_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_valid,
  input  logic [IW-1:0] I,
  input  logic [AW-1:0] PC,
  output logic          enable,
  output logic          unconditional,
  output logic          predict_taken,
  output logic [AW-1:0] next,
  output logic          stall,
  input  logic          resolve_valid,
  input  logic          resolve_taken,
  output logic          mispredict,
  output logic [AW-1:0] recover_pc,
  output logic [CW-1:0] pending_count
);
  ctr_t ctr_q [2**IDX_BITS];
  logic mispredict_q, mispredict_d;
  logic [AW-1:0] recover_pc_q, recover_pc_d;
  logic [IDX_BITS-1:0] idx;
  logic jump, full, empty, push, pop;
  pend_t entry, head;
  ctr_t head_ctr, ctr_d;
  logic unused_i;
  assign unused_i = ^I[IW-4:AW];
`ifdef BP_GLOBAL_HISTORY_EN
  logic [IDX_BITS-1:0] hist_q, hist_d;
  assign idx = PC[IDX_BITS-1:0] ^ hist_q;
  assign entry = '{hist: hist_q, idx: idx, pred: predict_taken, target: I[AW-1:0], fall: PC};
  // A mispredict rebuilds history from the resolving branch's snapshot, discarding wrong-path bits.
  assign hist_d = mispredict_d ? {head.hist[IDX_BITS-2:0], resolve_taken}
                : push ? {hist_q[IDX_BITS-2:0], predict_taken} : hist_q;
  always_ff @(posedge clk or posedge rst) hist_q <= rst ? '0 : hist_d;
`else
  assign idx = PC[IDX_BITS-1:0];
  assign entry = '{idx: idx, pred: predict_taken, target: I[AW-1:0], fall: PC};
`endif
  assign jump = I[IW-1] == OP_JUMP_MSB;
  assign unconditional = jump && I[IW-1:IW-3] == OP_JMP;
  assign enable = jump && !unconditional;
  assign predict_taken = enable && ctr_q[idx][1];
  assign stall = enable && full;
  assign next = (unconditional || (predict_taken && !stall)) ? I[AW-1:0] : PC;
  assign push = fetch_valid && enable && !stall;
  assign pop = resolve_valid && !empty;
  assign head_ctr = ctr_q[head.idx];
  always_comb begin
    ctr_d = resolve_taken ? (head_ctr == 2'b11 ? head_ctr : head_ctr + 2'b01)
                          : (head_ctr == 2'b00 ? head_ctr : head_ctr - 2'b01);
    mispredict_d = pop && resolve_taken != head.pred;
    recover_pc_d = mispredict_d ? (resolve_taken ? head.target : head.fall) : recover_pc_q;
  end
  bp_pending_fifo #(.DEPTH(PEND_DEPTH), .T(pend_t)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .flush_i(mispredict_d),
    .data_i(entry), .head_o(head), .full_o(full), .empty_o(empty), .count_o(pending_count)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2**IDX_BITS; k++) ctr_q[k] <= CTR_RESET;
      mispredict_q <= 1'b0;
      recover_pc_q <= '0;
    end else begin
      if (pop) ctr_q[head.idx] <= ctr_d;
      mispredict_q <= mispredict_d;
      recover_pc_q <= recover_pc_d;
    end
  end
  assign mispredict = mispredict_q;
  assign recover_pc = recover_pc_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed test-plan sequence plus random traffic checked against a queue/array reference model.
module tb_branch_predictor;
  logic clk = 0, rst = 1, fetch_valid = 0, resolve_valid = 0, resolve_taken = 0;
  logic [21:0] I = '0;
  logic [10:0] PC = '0;
  logic enable, unconditional, predict_taken, stall, mispredict;
  logic [10:0] next, recover_pc;
  logic [2:0] pending_count;
  int n_chk = 0, n_fail = 0;

  typedef struct {int idx; bit pred; int tgt; int fall; int hist;} ent_t;
  int m_cnt [16];
  ent_t m_q [$];
  int m_hist, m_rpc;
  bit m_mis;

  branch_predictor dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .I(I), .PC(PC),
    .enable(enable), .unconditional(unconditional), .predict_taken(predict_taken),
    .next(next), .stall(stall), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .mispredict(mispredict), .recover_pc(recover_pc), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [21:0] mk(input int op, input int tgt);
    logic [2:0] o = 3'(op);
    return {o, 8'h00, 11'(tgt)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_cnt[k] = 1;
    m_q.delete();
    m_hist = 0; m_rpc = 0; m_mis = 0;
  endtask

  task automatic do_reset();
    rst = 1; fetch_valid = 0; resolve_valid = 0;
    model_reset();
    @(posedge clk); #1;
    check("rst_count", pending_count, 0);
    check("rst_mis", mispredict, 0);
    check("rst_rpc", recover_pc, 0);
    rst = 0;
  endtask

  task automatic step(input bit fv, input logic [21:0] ins, input int pc, input bit rv, input bit rt);
    int op, idx, tgt, e_next;
    bit e_jmp, e_en, e_pt, e_stall, e_push;
    ent_t h;
    fetch_valid = fv; I = ins; PC = 11'(pc); resolve_valid = rv; resolve_taken = rt;
    #2;
    op = int'(ins[21:19]); tgt = int'(ins[10:0]);
    e_jmp = op == 4; e_en = op >= 5;
`ifdef BP_GLOBAL_HISTORY_EN
    idx = (pc ^ m_hist) & 15;
`else
    idx = pc & 15;
`endif
    e_pt = e_en && m_cnt[idx] >= 2;
    e_stall = e_en && m_q.size() == 4;
    e_next = (e_jmp || (e_pt && !e_stall)) ? tgt : pc;
    check("enable", enable, e_en);
    check("uncond", unconditional, e_jmp);
    check("pred", predict_taken, e_pt);
    check("stall", stall, e_stall);
    check("next", next, e_next);
    check("count", pending_count, m_q.size());
    check("mis", mispredict, m_mis);
    if (m_mis) check("rpc", recover_pc, m_rpc);
    e_push = fv && e_en && !e_stall;
    m_mis = 0;
    if (rv && m_q.size() > 0) begin
      h = m_q.pop_front();
      m_cnt[h.idx] = rt ? (m_cnt[h.idx] < 3 ? m_cnt[h.idx] + 1 : 3) : (m_cnt[h.idx] > 0 ? m_cnt[h.idx] - 1 : 0);
      if (rt != h.pred) begin
        m_mis = 1;
        m_rpc = rt ? h.tgt : h.fall;
        m_q.delete();
        m_hist = ((h.hist << 1) | int'(rt)) & 15;
      end
    end
    if (e_push && !m_mis) begin
      m_q.push_back('{idx, e_pt, tgt, pc, m_hist});
      m_hist = ((m_hist << 1) | int'(e_pt)) & 15;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();
    step(1, mk(5, 'h120), 5, 0, 0);
    check("tp1_count", pending_count, 1);
    step(0, mk(0, 0), 0, 1, 1);
    step(0, mk(0, 0), 0, 0, 0);
    step(1, mk(5, 'h120), 5, 0, 0);
    step(0, mk(0, 0), 0, 1, 1);
    step(1, mk(5, 'h120), 5, 0, 0);
    check("tp2_count", pending_count, 1);
    step(0, mk(0, 0), 0, 1, 1);
    step(1, mk(5, 'h120), 5, 0, 0);
    step(0, mk(0, 0), 0, 1, 1);
    for (int k = 0; k < 3; k++) step(1, mk(6, 'h120), 6 + k, 0, 0);
    check("tp3_pre", pending_count, 3);
    step(0, mk(0, 0), 0, 1, 1);
    check("tp3_mis", mispredict, 1);
    check("tp3_rpc", recover_pc, 'h120);
    check("tp3_count", pending_count, 0);
    step(0, mk(0, 0), 0, 0, 0);
    check("tp3_mis_drop", mispredict, 0);
    for (int k = 0; k < 5; k++) step(1, mk(7, 'h200 + k), 10 + k, 0, 0);
    check("tp4_count", pending_count, 4);
    step(1, mk(4, 'h3A0), 1, 0, 0);
    step(1, mk(2, 'h3A0), 2, 0, 0);
    step(1, mk(6, 'h055), 12, 1, 1);
    check("tp6_count", pending_count, 0);
    step(0, mk(0, 0), 0, 1, 0);
    step(0, mk(0, 0), 0, 0, 0);
    check("tp6_empty_mis", mispredict, 0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      step(1'($urandom_range(0, 3) != 0), mk($urandom_range(0, 7), $urandom_range(0, 2047)),
           $urandom_range(0, 23), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
